// File: rtl/rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_arbiter
// Description : Round-robin arbiter with registered one-hot grant, rotating
//               search pointer and optional per-ownership hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    localparam int                  c_HOLD_W    = $clog2(MAX_HOLD) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = (MAX_HOLD == 0) ? '0 : c_HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDW:0]        c_N         = (IDW + 1)'(N);
    localparam logic [IDW-1:0]      c_LAST_ID   = IDW'(N - 1);
    localparam logic [N-1:0]        c_ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_ptr;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [N-1:0]          r_grant;
    logic [IDW-1:0]        r_grant_id;
    logic                  r_grant_valid;
    logic                  r_timeout;

    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [IDW:0]          w_sum;
    logic [IDW-1:0]        w_next_ptr;
    logic                  w_owner_req;
    logic                  w_hold_expired;

    // Rotating search: first set request at or above r_ptr, wrapping past N-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (IDW + 1)'(i);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            if (!w_found && req[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDW-1:0];
            end
        end
    end

    assign w_next_ptr     = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + 1'b1;
    assign w_owner_req    = req[r_grant_id];
    assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_found) begin
                        r_grant       <= c_ONE << w_win;
                        r_grant_id    <= w_win;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // A release on the expiry edge wins, so timeout only flags forced revokes.
                    if (!w_owner_req || w_hold_expired) begin
                        r_grant       <= '0;
                        r_grant_id    <= '0;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= w_next_ptr;
                        r_timeout     <= w_owner_req;
                        r_state       <= S_IDLE;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_priority_arbiter
// Description : Directed vector bench for rr_priority_arbiter (N=8, MAX_HOLD=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_vec;
    int n_err;

    typedef struct packed {
        logic [7:0] req;
        logic [7:0] grant;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    rr_priority_arbiter #(
        .N        (8),
        .IDW      (3),
        .MAX_HOLD (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] eg, input logic [2:0] eid,
                       input logic ev, input logic eto);
        n_vec++;
        if (grant !== eg || grant_id !== eid || grant_valid !== ev || timeout !== eto) begin
            n_err++;
            $display("FAIL %s @%0t: got grant=%h id=%0d valid=%b timeout=%b, want grant=%h id=%0d valid=%b timeout=%b",
                     name, $time, grant, grant_id, grant_valid, timeout, eg, eid, ev, eto);
        end
    endtask

    // Drive req, let one rising edge pass, check on the following falling edge.
    task automatic step(input string name, input logic [7:0] r, input logic [7:0] eg,
                        input logic [2:0] eid, input logic ev, input logic eto);
        req = r;
        @(posedge clk);
        @(negedge clk);
        cmp(name, eg, eid, ev, eto);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'h00;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) tbl.push_back({8'h00, 8'h00, 3'd0, 1'b0, 1'b0});
        // Rotation 2 -> 4 -> 7 -> 2, each owner holds 3 cycles.
        tbl.push_back({8'h94, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h94, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h94, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h90, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back({8'h90, 8'h10, 3'd4, 1'b1, 1'b0});
        tbl.push_back({8'h90, 8'h10, 3'd4, 1'b1, 1'b0});
        tbl.push_back({8'h90, 8'h10, 3'd4, 1'b1, 1'b0});
        tbl.push_back({8'h84, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back({8'h84, 8'h80, 3'd7, 1'b1, 1'b0});
        tbl.push_back({8'h84, 8'h80, 3'd7, 1'b1, 1'b0});
        tbl.push_back({8'h84, 8'h80, 3'd7, 1'b1, 1'b0});
        tbl.push_back({8'h04, 8'h00, 3'd0, 1'b0, 1'b0});
        tbl.push_back({8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h04, 8'h04, 3'd2, 1'b1, 1'b0});
        tbl.push_back({8'h00, 8'h00, 3'd0, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        cmp("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            step($sformatf("table[%0d]", k), tbl[k].req, tbl[k].grant, tbl[k].id,
                 tbl[k].valid, tbl[k].to);
        end

        // Single requester held: 16 grant cycles, one timeout idle cycle, repeat.
        do_reset();
        for (int k = 0; k < 34; k++) begin
            if ((k % 17) < 16) step($sformatf("solo_hold[%0d]", k), 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
            else               step($sformatf("solo_hold[%0d]", k), 8'h01, 8'h00, 3'd0, 1'b0, 1'b1);
        end

        // Two requesters held: ownership alternates 0,1,0 through timeouts.
        do_reset();
        for (int k = 0; k < 51; k++) begin
            logic [2:0] own;
            own = ((k / 17) % 2 == 0) ? 3'd0 : 3'd1;
            if ((k % 17) < 16) step($sformatf("pair_hold[%0d]", k), 8'h03, 8'h01 << own, own, 1'b1, 1'b0);
            else               step($sformatf("pair_hold[%0d]", k), 8'h03, 8'h00, 3'd0, 1'b0, 1'b1);
        end

        // Owner 5 releases on the same edge its hold limit would expire.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step($sformatf("own5_hold[%0d]", k), 8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
        end
        step("own5_release_at_limit", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step("ptr_after_5", 8'h61, 8'h40, 3'd6, 1'b1, 1'b0);
        step("own6_release", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset during ownership of 3.
        do_reset();
        step("own3_grant", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        step("own3_hold", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("async_reset_clear", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_ptr0", 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
